// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core clock controller: command opcodes,
// controller states and the default halt status code.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_RSVD = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALT
    } state_e;

    localparam logic [7:0] HALT_CODE_DEFAULT = 8'hFF;

endpackage

// File: rtl/core_clock_div.sv
// Half-period divider for the core clock. While enabled, counts system
// clocks and toggles cclk every div+1 cycles; while disabled, holds cclk low
// with the counter cleared. The divide value is captured at each toggle so a
// new value only affects the following half-period.
module core_clock_div #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 cclk,
    output logic                 rise,
    output logic                 fall
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 terminal;

    assign terminal = en && (div_cnt == div_q);
    assign rise     = terminal && !cclk;
    assign fall     = terminal && cclk;

    // Half-period counter, divide-value capture and clock toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_q   <= '0;
            cclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            div_q   <= div;
            cclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            div_q   <= div;
            cclk    <= ~cclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_clock_ctrl.sv
// Core clock controller: generates CCLK in run/step modes, drains the
// current core cycle on stop or halt, registers core status and counts
// executed core cycles.
module core_clock_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [7:0]  HALT_CODE = HALT_CODE_DEFAULT
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [CNT_WIDTH-1:0] CMD_ARG,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 CRST,
    input  logic [7:0]           CSTAT,
    output logic                 CCLK,
    output logic [7:0]           CSTAT_Q,
    output logic                 BUSY,
    output logic                 HALTED,
    output logic [CNT_WIDTH-1:0] CYCLE_CNT
);

    state_e               state, state_nxt;
    logic                 halt_pend, halt_pend_nxt;
    logic [CNT_WIDTH-1:0] step_rem, step_rem_nxt;
    logic                 cclk_en;
    logic                 rise, fall;
    logic                 cmd_fire;
    logic                 halt_det;
    cmd_op_e              op;

    assign op       = cmd_op_e'(CMD_OP);
    assign cmd_fire = CMD_VALID && CMD_READY;
    assign halt_det = (CSTAT_Q == HALT_CODE) && !CRST;

    // Draining only continues clocking while the high half is still open,
    // so no new rising edge can be issued after a stop or halt.
    assign cclk_en = (state == ST_RUN) || (state == ST_STEP) ||
                     ((state == ST_DRAIN) && CCLK);

    core_clock_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .en    (cclk_en),
        .div   (DIV),
        .cclk  (CCLK),
        .rise  (rise),
        .fall  (fall)
    );

    // Next-state, step-count and halt-pending decode.
    always_comb begin
        state_nxt     = state;
        halt_pend_nxt = halt_pend;
        step_rem_nxt  = step_rem;
        case (state)
            ST_IDLE: begin
                halt_pend_nxt = 1'b0;
                if (cmd_fire) begin
                    if (op == OP_RUN) begin
                        state_nxt = ST_RUN;
                    end else if ((op == OP_STEP) && (CMD_ARG != '0)) begin
                        state_nxt    = ST_STEP;
                        step_rem_nxt = CMD_ARG;
                    end
                end
            end
            ST_RUN: begin
                if (halt_det) begin
                    state_nxt     = ST_DRAIN;
                    halt_pend_nxt = 1'b1;
                end else if (cmd_fire && (op == OP_STOP)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (rise) begin
                    step_rem_nxt = step_rem - CNT_WIDTH'(1);
                end
                if (halt_det) begin
                    state_nxt     = ST_DRAIN;
                    halt_pend_nxt = 1'b1;
                end else if (rise && (step_rem == CNT_WIDTH'(1))) begin
                    state_nxt = ST_DRAIN;
                end else if (cmd_fire && (op == OP_STOP)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!CCLK || fall) begin
                    state_nxt    = halt_pend ? ST_HALT : ST_IDLE;
                    step_rem_nxt = '0;
                end
            end
            ST_HALT: begin
                halt_pend_nxt = 1'b0;
                if (CRST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered decodes, taken from the next state so
    // they line up with the state they describe.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state     <= ST_IDLE;
            halt_pend <= 1'b0;
            step_rem  <= '0;
            BUSY      <= 1'b0;
            HALTED    <= 1'b0;
            CMD_READY <= 1'b0;
        end else begin
            state     <= state_nxt;
            halt_pend <= halt_pend_nxt;
            step_rem  <= step_rem_nxt;
            BUSY      <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP) ||
                         (state_nxt == ST_DRAIN);
            HALTED    <= (state_nxt == ST_HALT);
            CMD_READY <= (state_nxt != ST_DRAIN);
        end
    end

    // Core status capture with fixed one-cycle latency.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            CSTAT_Q <= '0;
        end else begin
            CSTAT_Q <= CSTAT;
        end
    end

    // Executed core cycle counter; held at zero while the core is in reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            CYCLE_CNT <= '0;
        end else if (CRST) begin
            CYCLE_CNT <= '0;
        end else if (rise) begin
            CYCLE_CNT <= CYCLE_CNT + 1'b1;
        end
    end

endmodule

// File: doc/core_clock_ctrl.md
Name: core_clock_ctrl

Overview:
- Generates the core clock CCLK from the AXI clock, with run, stop and single/multi-step modes commanded by the controller's register file.
- Registers the core status CSTAT for the controller and halts the core clock when the core reports HALT_CODE.
- Counts executed core cycles.
- Sits between the core and core_controller: drives CCLK to both, and consumes CRST and CSTAT.

Parameters:
- DIV_WIDTH, 16, width of the half-period divider value.
- CNT_WIDTH, 32, width of the step argument and the cycle counter.
- HALT_CODE, 8'hFF, CSTAT value that means the core has halted.

Ports:
- S_AXI_ACLK  in  1  system clock; all logic is on the rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command ready; a command transfers when VALID && READY.
- CMD_OP  in  2  00 STOP, 01 RUN, 10 STEP, 11 reserved (accepted, no effect).
- CMD_ARG  in  CNT_WIDTH  step count for STEP.
- DIV  in  DIV_WIDTH  half-period of CCLK in S_AXI_ACLK cycles, minus 1; sampled whenever a half-period completes.
- CRST  in  1  core reset from core_controller, active-high.
- CSTAT  in  8  status from the core.
- CCLK  out  1  core clock.
- CSTAT_Q  out  8  CSTAT registered once.
- BUSY  out  1  high in RUN, STEP or DRAIN.
- HALTED  out  1  high in HALT.
- CYCLE_CNT  out  CNT_WIDTH  count of CCLK rising edges.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - State IDLE.
  - CCLK=0, CSTAT_Q=0, CYCLE_CNT=0.
  - div_cnt=0, step_rem=0.
  - BUSY=0, HALTED=0, CMD_READY=0.
  - CMD_READY rises on the first clock after reset release.
- States: IDLE, RUN, STEP, DRAIN, HALT.
- Clock generation:
  - Active only in RUN, STEP and DRAIN.
  - div_cnt increments each cycle. When div_cnt==DIV, CCLK toggles and div_cnt clears.
  - DIV=0 gives CCLK = S_AXI_ACLK/2.
  - A new DIV value takes effect from the next half-period.
- In IDLE and HALT:
  - CCLK is held low and div_cnt=0.
  - The first toggle happens DIV+1 cycles after entering RUN or STEP.
- CMD_READY:
  - 1 in IDLE, RUN, STEP and HALT.
  - 0 in DRAIN.
- IDLE transitions:
  - RUN goes to RUN.
  - STEP with ARG>0 goes to STEP and loads step_rem=ARG.
  - STEP with ARG=0 is accepted with no state change.
  - STOP is accepted with no effect.
- RUN: STOP goes to DRAIN. RUN and STEP commands are accepted and ignored.
- STEP:
  - step_rem decrements on each CCLK rising edge.
  - The rising edge that brings step_rem to 0 goes to DRAIN.
  - STOP goes to DRAIN. RUN and STEP commands are ignored.
- DRAIN:
  - If CCLK=0, go to IDLE on the next cycle; no further rising edge is issued.
  - If CCLK=1, complete the high half-period; on the falling edge go to IDLE.
  - A core cycle is therefore never truncated.
- Halt detection:
  - In RUN or STEP, if CSTAT_Q==HALT_CODE, drain the current cycle as in DRAIN, then go to HALT instead of IDLE.
  - Halt takes priority over step completion and over STOP when both occur in the same cycle.
- HALT:
  - HALTED=1. RUN and STEP commands are accepted and ignored.
  - Leave to IDLE only when CRST=1.
- CRST:
  - While CRST=1, CYCLE_CNT holds 0 and halt detection is masked.
  - CCLK keeps running in RUN or STEP so the core sees reset clocks; step_rem still decrements.
- CYCLE_CNT: increments on each CCLK rising edge and wraps modulo 2^CNT_WIDTH.
- Timing: CSTAT_Q <= CSTAT every cycle, a fixed one-cycle latency. BUSY and HALTED are registered decodes of the state.
- Simultaneous events: a command accepted in the same cycle a step completes applies only to the resulting state on the next cycle; a command presented during DRAIN waits for CMD_READY.

Decomposition:
- Package core_ctrl_pkg:
  - CMD_OP encodings (OP_STOP, OP_RUN, OP_STEP).
  - State enumeration.
  - Default HALT_CODE.
- Sub-module core_clock_div: div_cnt, CCLK toggle, and rise/fall strobes, with enable and DIV input.
- The FSM, step counter and cycle counter stay in core_clock_ctrl.

Test Plan:
- Reset, then DIV=0, RUN for 20 cycles, then STOP:
  - CCLK period is 2 cycles.
  - After STOP, CCLK ends low; CYCLE_CNT matches the rising-edge count; BUSY=0.
- DIV=3, STEP ARG=5:
  - Exactly 5 rising edges with 8-cycle period.
  - CYCLE_CNT=5; IDLE with CCLK=0 after the 5th falling edge.
- STOP issued while CCLK=1, mid-step:
  - CMD_READY=0 until the falling edge.
  - No further rising edge; step_rem is discarded.
- CSTAT=8'hFF during RUN:
  - CSTAT_Q follows after 1 cycle.
  - Current cycle completes, HALTED=1, and CCLK is held low.
  - A subsequent RUN has no effect; CRST=1 returns the block to IDLE and clears CYCLE_CNT.
- STEP ARG=0, and op 11:
  - Both accepted, no CCLK edges, state stays IDLE.
- ARESETN asserted mid-RUN with CCLK=1:
  - CCLK=0, CYCLE_CNT=0 and IDLE immediately, without waiting for a clock edge.
